// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(7,4) types, widths and parity function
package hamming_pkg;

    typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

    localparam int HAM_DATA_W = 4;
    localparam int HAM_PAR_W  = 3;

    // Bit order matches the syndrome decoder: flips of d3/d2/d1/d0 give 011/101/110/111.
    function automatic logic [HAM_PAR_W-1:0] hamming74_parity(input logic [HAM_DATA_W-1:0] d);
        return {d[0] ^ d[1] ^ d[2],
                d[0] ^ d[1] ^ d[3],
                d[0] ^ d[2] ^ d[3]};
    endfunction

endpackage

// File: rtl/hamming74_enc.sv
// rtl/hamming74_enc.sv - combinational Hamming(7,4) parity for one 4-bit block
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [HAM_DATA_W-1:0] data,
    output logic [HAM_PAR_W-1:0]  parity
);

    assign parity = hamming74_parity(data);

endmodule

// File: rtl/hamming_snapshot_encoder.sv
// rtl/hamming_snapshot_encoder.sv - captures the counter on enable fall, encodes one block per cycle, offers it
module hamming_snapshot_encoder
    import hamming_pkg::*;
#(
    parameter  int WIDTH       = 4,
    localparam int BLOCKS      = WIDTH / HAM_DATA_W,
    localparam int PARITY_BITS = BLOCKS * HAM_PAR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   snap_ready,
    output logic                   snap_valid,
    output logic [WIDTH-1:0]       snap_data,
    output logic [PARITY_BITS-1:0] snap_parity,
    output logic                   busy,
    output logic                   overrun
);

    localparam int IDX_W = $clog2(BLOCKS) + 1;

    state_t                 state, state_next;
    logic                   enable_q;
    logic [IDX_W-1:0]       blk_idx;
    logic                   trigger, handshake, last_blk;
    logic                   capture, encode_step, drop;
    logic [HAM_DATA_W-1:0]  enc_data;
    logic [HAM_PAR_W-1:0]   enc_parity;

    assign trigger   = enable_q & ~enable;
    assign handshake = snap_valid & snap_ready;
    assign last_blk  = (blk_idx == IDX_W'(BLOCKS - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        encode_step = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    capture    = 1'b1;
                    state_next = ENCODE;
                end
            end
            ENCODE: begin
                encode_step = 1'b1;
                drop        = trigger;
                if (last_blk) state_next = HOLD;
            end
            HOLD: begin
                // A trigger landing on the accepting cycle starts the next snapshot back to back.
                if (handshake) begin
                    if (trigger) begin
                        capture    = 1'b1;
                        state_next = ENCODE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    drop = trigger;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enc_data = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            if (blk_idx == IDX_W'(i)) enc_data = snap_data[i*HAM_DATA_W +: HAM_DATA_W];
        end
    end

    hamming74_enc u_enc (
        .data   (enc_data),
        .parity (enc_parity)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            enable_q    <= 1'b0;
            blk_idx     <= '0;
            snap_valid  <= 1'b0;
            snap_data   <= '0;
            snap_parity <= '0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_next;
            enable_q   <= enable;
            snap_valid <= (state_next == HOLD);
            if (drop) overrun <= 1'b1;
            if (capture) begin
                snap_data   <= data_in;
                snap_parity <= '0;
                blk_idx     <= '0;
            end else if (encode_step) begin
                for (int i = 0; i < BLOCKS; i++) begin
                    if (blk_idx == IDX_W'(i)) snap_parity[i*HAM_PAR_W +: HAM_PAR_W] <= enc_parity;
                end
                blk_idx <= blk_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_snapshot_encoder.sv
// tb/tb_hamming_snapshot_encoder.sv - scoreboard bench for hamming_snapshot_encoder at WIDTH=16
module tb_hamming_snapshot_encoder;

    localparam int WIDTH  = 16;
    localparam int BLOCKS = 4;
    localparam int PB     = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              snap_ready = 1'b0;
    logic              snap_valid;
    logic [WIDTH-1:0]  snap_data;
    logic [PB-1:0]     snap_parity;
    logic              busy;
    logic              overrun;

    hamming_snapshot_encoder #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .snap_ready  (snap_ready),
        .snap_valid  (snap_valid),
        .snap_data   (snap_data),
        .snap_parity (snap_parity),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_par(input logic [3:0] d);
        logic [2:0] p;
        p[0] = d[0] ^ d[2] ^ d[3];
        p[1] = d[0] ^ d[1] ^ d[3];
        p[2] = d[0] ^ d[1] ^ d[2];
        return p;
    endfunction

    function automatic logic [PB-1:0] ref_word(input logic [WIDTH-1:0] d);
        logic [PB-1:0] p;
        for (int b = 0; b < BLOCKS; b++) p[b*3 +: 3] = ref_par(d[b*4 +: 4]);
        return p;
    endfunction

    // Reference model, stepped on the same edges as the DUT.
    typedef enum int {M_IDLE, M_ENC, M_HOLD} m_state_t;
    m_state_t             m_state = M_IDLE;
    int                   m_cnt   = 0;
    bit                   m_en_q  = 1'b0;
    bit                   m_ovr   = 1'b0;
    bit                   m_trig;
    bit                   mon_on  = 1'b0;
    logic [WIDTH+PB-1:0]  sb[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_en_q  = 1'b0;
            m_ovr   = 1'b0;
            sb.delete();
        end else begin
            m_trig = m_en_q && !enable;
            case (m_state)
                M_IDLE: if (m_trig) begin
                    sb.push_back({data_in, ref_word(data_in)});
                    m_state = M_ENC;
                    m_cnt   = 0;
                end
                M_ENC: begin
                    if (m_trig) m_ovr = 1'b1;
                    m_cnt++;
                    if (m_cnt == BLOCKS) m_state = M_HOLD;
                end
                M_HOLD: begin
                    if (snap_ready) begin
                        if (m_trig) begin
                            sb.push_back({data_in, ref_word(data_in)});
                            m_state = M_ENC;
                            m_cnt   = 0;
                        end else begin
                            m_state = M_IDLE;
                        end
                    end else if (m_trig) begin
                        m_ovr = 1'b1;
                    end
                end
                default: m_state = M_IDLE;
            endcase
            m_en_q = enable;
        end
    end

    always @(negedge clk) begin
        if (!reset && mon_on) begin
            check("valid", snap_valid, m_state == M_HOLD);
            check("busy", busy, m_state != M_IDLE);
            check("overrun", overrun, m_ovr);
            if (m_state == M_HOLD) begin
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("snap_data", snap_data, sb[0][WIDTH+PB-1:PB]);
                    check("snap_parity", snap_parity, sb[0][PB-1:0]);
                    if (snap_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic en, input logic [WIDTH-1:0] d, input logic rdy);
        @(posedge clk);
        #1;
        enable     = en;
        data_in    = d;
        snap_ready = rdy;
    endtask

    task automatic snapshot(input logic [WIDTH-1:0] d);
        cyc(1'b1, d, 1'b0);
        cyc(1'b0, d, 1'b0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (snap_valid) break;
        end
        if (!snap_valid) check("valid_timeout", snap_valid, 1);
    endtask

    task automatic accept();
        cyc(1'b1, data_in, 1'b1);
        cyc(1'b1, data_in, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [2:0]  syn_tab [4];
    logic [3:0]  nib, flip, fixed;
    logic [2:0]  par, syn;
    logic [WIDTH-1:0] w;
    int          lat;

    initial begin
        syn_tab = '{3'b111, 3'b110, 3'b101, 3'b011};
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", snap_valid, 0);
        check("rst_data", snap_data, 0);
        check("rst_parity", snap_parity, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // Single-nibble value and its latency.
        snapshot(16'h000B);
        wait_valid(lat);
        check("latency", lat, BLOCKS + 1);
        check("par_000B", snap_parity, 12'h002);
        cyc(1'b1, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        check("valid_drop", snap_valid, 0);
        check("busy_idle", busy, 0);
        cyc(1'b1, 16'h0, 1'b0);

        // Held offer under back-pressure.
        snapshot(16'h00A5);
        wait_valid(lat);
        check("par_00A5", snap_parity, 12'h02A);
        repeat (5) cyc(1'b1, $urandom, 1'b0);
        check("hold_data", snap_data, 16'h00A5);
        accept();

        // Syndrome loop-back over every 4-bit value.
        for (int d = 0; d < 16; d += 4) begin
            w = {4'(d + 3), 4'(d + 2), 4'(d + 1), 4'(d)};
            snapshot(w);
            wait_valid(lat);
            for (int b = 0; b < BLOCKS; b++) begin
                nib = snap_data[b*4 +: 4];
                par = snap_parity[b*3 +: 3];
                check("syn_clean", par ^ ref_par(nib), 0);
                for (int k = 0; k < 4; k++) begin
                    flip = nib ^ (4'b1 << k);
                    syn  = par ^ ref_par(flip);
                    check("syndrome", syn, syn_tab[k]);
                    fixed = flip;
                    for (int j = 0; j < 4; j++) if (syn_tab[j] == syn) fixed = flip ^ (4'b1 << j);
                    check("corrected", fixed, nib);
                end
            end
            accept();
        end

        // Dropped trigger while held.
        snapshot(16'hBEEF);
        wait_valid(lat);
        cyc(1'b1, 16'h1111, 1'b0);
        cyc(1'b0, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        check("overrun_set", overrun, 1);
        check("overrun_data", snap_data, 16'hBEEF);
        accept();
        do_reset();
        check("overrun_clr", overrun, 0);

        // Trigger coincident with the handshake.
        snapshot(16'h3C3C);
        wait_valid(lat);
        cyc(1'b1, 16'h3C3C, 1'b0);
        cyc(1'b0, 16'h5A69, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_busy", busy, 1);
        check("b2b_valid", snap_valid, 0);
        check("b2b_overrun", overrun, 0);
        snap_ready = 1'b0;
        wait_valid(lat);
        check("b2b_data", snap_data, 16'h5A69);
        check("b2b_parity", snap_parity, ref_word(16'h5A69));
        accept();

        // Asynchronous reset mid-encode, released with enable high.
        snapshot(16'h1234);
        @(posedge clk);
        #1;
        check("enc_busy", busy, 1);
        @(posedge clk);
        #2;
        enable = 1'b1;
        reset  = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_data", snap_data, 0);
        check("arst_parity", snap_parity, 0);
        check("arst_valid", snap_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) cyc(1'b1, 16'hFFFF, 1'b0);
        check("no_spurious", busy, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (20) cyc(1'b1, 16'h0, 1'b1);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
